exwb_skid_stage: RTL and testbench

Parametrised EX/WB pipeline stage: carries the writeback bundle (mem_to_reg, data_mem, reg_wrt, rd, adder, svpc) from execute to writeback. Unlike a plain clocked latch, it has a valid/ready handshake, a 2-entry skid buffer so upstream stalls resolve without combinational ready paths, synchronous flush, and reset. An optional forwarding tap exposes the oldest in-flight writeback to the hazard unit.

---
 rtl/exwb_skid_stage.sv | 142 ++++++++++++++
 tb/tb_exwb_skid_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exwb_skid_stage.sv
// EX/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer (head H, skid S).
// Optional forwarding tap of the head entry is enabled by defining EXWB_FWD_EN.
module exwb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_to_reg,
    input  logic              reg_wrt,
    input  logic              svpc,
    input  logic [DATA_W-1:0] data_mem,
    input  logic [DATA_W-1:0] adder,
    input  logic [RD_W-1:0]   rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_to_reg_out,
    output logic              reg_wrt_out,
    output logic              svpc_out,
    output logic [DATA_W-1:0] data_mem_out,
    output logic [DATA_W-1:0] adder_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [1:0]        occupancy,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = 2 * DATA_W + RD_W + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] head_q, skid_q, in_bundle;
    logic          load_h, load_s, h_from_s;
    logic          push, pop;

    assign in_bundle = {mem_to_reg, reg_wrt, svpc, rd, data_mem, adder};

    // Ready depends only on registered state so upstream never sees a combinational path from out_ready.
    assign in_ready  = (state != FULL) & rst_n;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_h    = 1'b0;
        load_s    = 1'b0;
        h_from_s  = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_h    = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                    load_s    = 1'b1;
                end else if (push && pop) begin
                    load_h    = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    h_from_s  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush squashes everything, including the bundle offered this cycle.
        if (flush) begin
            state_nxt = EMPTY;
            load_h    = 1'b0;
            load_s    = 1'b0;
            h_from_s  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_h) begin
                head_q <= in_bundle;
            end else if (h_from_s) begin
                head_q <= skid_q;
            end
            if (load_s) begin
                skid_q <= in_bundle;
            end
        end
    end

    assign adder_out      = head_q[DATA_W-1:0];
    assign data_mem_out   = head_q[2*DATA_W-1:DATA_W];
    assign rd_out         = head_q[2*DATA_W+RD_W-1:2*DATA_W];
    assign svpc_out       = head_q[PW-3];
    assign reg_wrt_out    = head_q[PW-2];
    assign mem_to_reg_out = head_q[PW-1];

    assign wb_data = mem_to_reg_out ? data_mem_out : adder_out;
    assign wb_en   = out_valid & out_ready & reg_wrt_out;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef EXWB_FWD_EN
    // Register 0 is hardwired, so a write to it is never worth forwarding.
    assign fwd_valid = out_valid & reg_wrt_out & (rd_out != '0);
    assign fwd_rd    = rd_out;
    assign fwd_data  = wb_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_exwb_skid_stage.sv
// Self-checking bench for exwb_skid_stage: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the stage.
module tb_exwb_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic        mem_to_reg, reg_wrt, svpc;
    logic [31:0] data_mem, adder;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic        mem_to_reg_out, reg_wrt_out, svpc_out;
    logic [31:0] data_mem_out, adder_out, wb_data, fwd_data;
    logic [4:0]  rd_out, fwd_rd;
    logic        wb_en, fwd_valid;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic        sv;
        logic [4:0]  rd;
        logic [31:0] dm;
        logic [31:0] ad;
    } bundle_t;

    bundle_t q[$];
    bundle_t last_head;
    bit      model_ok = 1'b0;

    exwb_skid_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_to_reg(mem_to_reg), .reg_wrt(reg_wrt), .svpc(svpc),
        .data_mem(data_mem), .adder(adder), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_to_reg_out(mem_to_reg_out), .reg_wrt_out(reg_wrt_out), .svpc_out(svpc_out),
        .data_mem_out(data_mem_out), .adder_out(adder_out), .rd_out(rd_out),
        .wb_data(wb_data), .wb_en(wb_en), .occupancy(occupancy),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] r, input logic [31:0] ad,
                                 input logic [31:0] dm, input logic m2r, input logic rw,
                                 input logic sv, input logic ordy, input logic fl);
        in_valid   = v;
        rd         = r;
        adder      = ad;
        data_mem   = dm;
        mem_to_reg = m2r;
        reg_wrt    = rw;
        svpc       = sv;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is a FIFO of at most two bundles; the head registers keep the last head when empty.
    always @(posedge clk) begin
        bit push_m, pop_m;
        push_m = in_valid && rst_n && (q.size() < 2);
        pop_m  = (q.size() > 0) && out_ready;
        if (!rst_n) begin
            q.delete();
            last_head = '0;
            model_ok  = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back({mem_to_reg, reg_wrt, svpc, rd, data_mem, adder});
        end
        if (q.size() > 0) last_head = q[0];
    end

    always @(negedge clk) begin
        bundle_t     h;
        logic [31:0] exp_wb;
        logic        exp_fv;
        if (model_ok) begin
            h      = (q.size() > 0) ? q[0] : last_head;
            exp_wb = h.m2r ? h.dm : h.ad;
            checkOutput("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            checkOutput("m_occupancy", 32'(occupancy), 32'(q.size()));
            checkOutput("m_in_ready", 32'(in_ready), 32'(rst_n && q.size() < 2));
            checkOutput("m_rd_out", 32'(rd_out), 32'(h.rd));
            checkOutput("m_adder_out", adder_out, h.ad);
            checkOutput("m_data_mem_out", data_mem_out, h.dm);
            checkOutput("m_ctrl_out", 32'({mem_to_reg_out, reg_wrt_out, svpc_out}),
                        32'({h.m2r, h.rw, h.sv}));
            checkOutput("m_wb_data", wb_data, exp_wb);
            checkOutput("m_wb_en", 32'(wb_en), 32'((q.size() > 0) && out_ready && h.rw));
`ifdef EXWB_FWD_EN
            exp_fv = (q.size() > 0) && h.rw && (h.rd != 5'd0);
            checkOutput("m_fwd_valid", 32'(fwd_valid), 32'(exp_fv));
            checkOutput("m_fwd_rd", 32'(fwd_rd), 32'(h.rd));
            checkOutput("m_fwd_data", fwd_data, exp_wb);
`else
            exp_fv = 1'b0;
            checkOutput("m_fwd_zero", 32'({fwd_valid, fwd_rd}) | fwd_data, 32'(exp_fv));
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd7, 32'h77, 32'h99, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset held two cycles with traffic offered
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_payload", adder_out | data_mem_out | 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rel_out_valid", 32'(out_valid), 32'd0);

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 32'hAAAA0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            checkOutput("stream_rd", 32'(rd_out), 32'(i));
            checkOutput("stream_wb_data", wb_data, 32'h100 + 32'(i));
            checkOutput("stream_occ", 32'(occupancy), 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_drain_occ", 32'(occupancy), 32'd0);

        // Backpressure
        applyStimulus(1'b1, 5'd3, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_occ_full", 32'(occupancy), 32'd2);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 5'd5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_head_rd", 32'(rd_out), 32'd3);
        checkOutput("bp_occ_hold", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_second_rd", 32'(rd_out), 32'd4);
        tick();
        checkOutput("bp_third_rd", 32'(rd_out), 32'd5);
        in_valid = 1'b0;
        tick();
        checkOutput("bp_drain_occ", 32'(occupancy), 32'd0);

        // Flush while full, with an input offered on the flush cycle
        applyStimulus(1'b1, 5'd6, 32'h6, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rd = 5'd7;
        adder = 32'h7;
        tick();
        applyStimulus(1'b1, 5'd9, 32'h9, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_no_rd9", 32'(rd_out), 32'd6);
        checkOutput("flush_still_empty", 32'(out_valid), 32'd0);

        // Writeback select and forwarding
        applyStimulus(1'b1, 5'd2, 32'h4, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sel_wb_data", wb_data, 32'hDEADBEEF);
        checkOutput("sel_wb_en", 32'(wb_en), 32'd1);
        reg_wrt = 1'b0;
        tick();
        checkOutput("sel_wb_en_off", 32'(wb_en), 32'd0);
        applyStimulus(1'b1, 5'd5, 32'h4, 32'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("svpc_pass", 32'(svpc_out), 32'd1);
`ifdef EXWB_FWD_EN
        checkOutput("fwd_valid_rd5", 32'(fwd_valid), 32'd1);
        checkOutput("fwd_rd_rd5", 32'(fwd_rd), 32'd5);
        checkOutput("fwd_data_rd5", fwd_data, 32'h55);
`else
        checkOutput("fwd_off_valid", 32'(fwd_valid), 32'd0);
        checkOutput("fwd_off_data", fwd_data, 32'd0);
`endif
        rd = 5'd0;
        tick();
        checkOutput("fwd_valid_rd0", 32'(fwd_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        // Randomized traffic, including occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, $urandom,
                          1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("final_empty", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
